// File: rtl/wb_arbiter.sv
// Purpose : three-way register-file writeback arbiter (load unit, integer pipe, quantum unit)
// Latency : ready is combinational in the request cycle; the winning write appears on rf_* one cycle later
// Backpres: no buffering; a denied requester sees ready low and must hold valid/inputs; quantum is promoted
//           to top priority after STARVE_LIMIT consecutive denied cycles
//
// Ports:
//   clk, rst                         single clock, asynchronous active-high reset
//   ld_valid/ld_ready/ld_rd/ld_data  load-unit writeback request (wb_src 00)
//   pipe_valid/pipe_ready/pipe_rd    integer pipe writeback request; pipe_sel picks
//   pipe_sel/pipe_alu/pipe_pc4         pipe_alu (wb_src 01) or pipe_pc4 (wb_src 10)
//   qm_valid/qm_ready/qm_rd/qm_data  quantum measurement writeback request (wb_src 11)
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   wb_src                           source of the most recent transfer
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,

    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  logic [4:0]  pipe_rd,
    input  logic        pipe_sel,
    input  logic [31:0] pipe_alu,
    input  logic [31:0] pipe_pc4,

    input  logic        qm_valid,
    output logic        qm_ready,
    input  logic [4:0]  qm_rd,
    input  logic [31:0] qm_data,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  wb_src
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    localparam logic [1:0] SRC_MEM = 2'b00;
    localparam logic [1:0] SRC_ALU = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;
    localparam logic [1:0] SRC_QM  = 2'b11;

    // Registered state
    logic [3:0]  starve_q,   starve_d;
    logic        rf_we_q,    rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [1:0]  wb_src_q,   wb_src_d;

    // Arbitration results
    logic        qm_promote;
    logic        ld_gnt;
    logic        pipe_gnt;
    logic        qm_gnt;
    logic        any_xfer;

    // Winner's payload
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [1:0]  sel_src;

    // ------------------------------------------------------------------
    // Grant decision. Grants are one-hot and imply the matching valid, so
    // a grant is the same thing as a transfer this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        qm_promote = qm_valid && (starve_q == STARVE_MAX);
        ld_gnt     = 1'b0;
        pipe_gnt   = 1'b0;
        qm_gnt     = 1'b0;
        // Readies are held low for the whole time reset is asserted so no
        // handshake can complete against flops that are being cleared.
        if (!rst) begin
            if (qm_promote) begin
                qm_gnt = 1'b1;
            end else if (ld_valid) begin
                ld_gnt = 1'b1;
            end else if (pipe_valid) begin
                pipe_gnt = 1'b1;
            end else if (qm_valid) begin
                qm_gnt = 1'b1;
            end
        end
        any_xfer = ld_gnt || pipe_gnt || qm_gnt;
    end

    assign ld_ready   = ld_gnt;
    assign pipe_ready = pipe_gnt;
    assign qm_ready   = qm_gnt;

    // ------------------------------------------------------------------
    // Payload mux for the winning requester.
    // ------------------------------------------------------------------
    always_comb begin
        sel_rd   = 5'd0;
        sel_data = 32'd0;
        sel_src  = wb_src_q;
        if (ld_gnt) begin
            sel_rd   = ld_rd;
            sel_data = ld_data;
            sel_src  = SRC_MEM;
        end else if (pipe_gnt) begin
            sel_rd   = pipe_rd;
            sel_data = pipe_sel ? pipe_pc4 : pipe_alu;
            sel_src  = pipe_sel ? SRC_PC4 : SRC_ALU;
        end else if (qm_gnt) begin
            sel_rd   = qm_rd;
            sel_data = qm_data;
            sel_src  = SRC_QM;
        end
    end

    // ------------------------------------------------------------------
    // Next write-port state. Writes to x0 still complete the handshake and
    // record the source, but never raise the write enable.
    // ------------------------------------------------------------------
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = 32'd0;
        wb_src_d   = wb_src_q;
        if (any_xfer) begin
            wb_src_d = sel_src;
            if (sel_rd != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = sel_rd;
                rf_wdata_d = sel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles the quantum unit waits.
    // Once it reaches the limit the quantum request wins that same cycle,
    // so the saturation branch only guards against an out-of-range limit.
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (!qm_valid || qm_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q >= STARVE_MAX) begin
            starve_d = STARVE_MAX;
        end else begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            wb_src_q   <= SRC_MEM;
        end else begin
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_src   = wb_src_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles after which the quantum requester is promoted to top priority (legal range 1-15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ld_valid input 1, ld_ready output 1, ld_rd input 5, ld_data input 32: load-unit writeback request (mem_out source).
REQ-005 SHALL have ports pipe_valid input 1, pipe_ready output 1, pipe_rd input 5, pipe_sel input 1 (0=ALU, 1=PC+4), pipe_alu input 32, pipe_pc4 input 32: integer pipeline writeback request.
REQ-006 SHALL have ports qm_valid input 1, qm_ready output 1, qm_rd input 5, qm_data input 32: quantum measurement unit writeback request.
REQ-007 SHALL have port rf_we  output  1  register-file write enable.
REQ-008 SHALL have port rf_waddr  output  5  register-file write address.
REQ-009 SHALL have port rf_wdata  output  32  register-file write data.
REQ-010 SHALL have port wb_src  output  2  source of last write: 00 mem, 01 ALU, 10 PC+4, 11 quantum.

Function
REQ-011 SHALL treat a transfer on a requester as valid & ready high in the same cycle; requester inputs are sampled only on transfer.
REQ-012 SHALL drive ready combinationally from current valids and starvation state; at most one ready high per cycle; ready never high for a requester whose valid is low.
REQ-013 SHALL use normal fixed priority load > pipe > quantum.
REQ-014 SHALL, when starvation counter equals STARVE_LIMIT and qm_valid is high, grant quantum ahead of load and pipe for that cycle.
REQ-015 SHALL increment the 4-bit starvation counter each cycle qm_valid is high and qm is not granted, saturating at STARVE_LIMIT.
REQ-016 SHALL clear the starvation counter on a quantum transfer or any cycle qm_valid is low.
REQ-017 SHALL register write outputs with exactly one cycle latency: the edge ending a transfer cycle loads rf_waddr=rd, rf_wdata=selected data, wb_src per REQ-010, rf_we=1.
REQ-018 SHALL select pipe data as pipe_alu when pipe_sel=0 (wb_src 01) and pipe_pc4 when pipe_sel=1 (wb_src 10).
REQ-019 SHALL, on a transfer with rd=0, complete the handshake but register rf_we=0, rf_waddr=0, rf_wdata=0, wb_src updated to the source.
REQ-020 SHALL, on a cycle with no transfer, register rf_we=0, rf_waddr=0, rf_wdata=0 and hold wb_src.
REQ-021 SHALL sustain one transfer per cycle back-to-back with no bubbles.
REQ-022 SHALL not buffer requests; a denied requester holds valid and its inputs stable until ready.
REQ-023 SHALL, with STARVE_LIMIT=1, promote quantum after a single denied cycle.

Reset
REQ-024 SHALL, while rst is high, force ld_ready, pipe_ready, qm_ready low regardless of valids.
REQ-025 SHALL, on rst assertion (asynchronous, mid-operation included), immediately set rf_we=0, rf_waddr=0, rf_wdata=0, wb_src=00, starvation counter=0; a request in flight at reset is dropped with no write.
REQ-026 SHALL resume normal arbitration on the first rising edge after rst deasserts.

Verification
REQ-027 SHALL cover: pipe_valid=1, pipe_rd=5, pipe_sel=0, pipe_alu=0x1234 alone -> pipe_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_src=01.
REQ-028 SHALL cover: ld_valid and pipe_valid both high (ld_rd=3, ld_data=0xA5A5A5A5) -> ld_ready=1, pipe_ready=0; next cycle rf_waddr=3, wb_src=00; pipe granted following cycle, writes with wb_src per pipe_sel.
REQ-029 SHALL cover: STARVE_LIMIT=4, ld_valid held high continuously with qm_valid high -> qm denied 4 cycles, qm_ready=1 in 5th cycle with ld_ready=0, wb_src=11 one cycle later, counter back to 0.
REQ-030 SHALL cover: pipe transfer with pipe_rd=0, pipe_sel=1 -> pipe_ready=1; next cycle rf_we=0, rf_waddr=0, rf_wdata=0, wb_src=10.
REQ-031 SHALL cover: rst asserted mid-cycle between edges during a load transfer -> rf_we, readies drop to 0 immediately without a clock edge; no write of that load after rst deasserts.
REQ-032 SHALL cover: all three valids high for 20 cycles with STARVE_LIMIT=4 -> exactly one ready per cycle, rf_we=1 every cycle after the first, quantum granted every 5th cycle, pipe never granted.
